// File: rtl/instr_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instr_mem
// Purpose  : 256x32 instruction memory with a combinational fetch port and a
//            byte-streaming program loader. Fetch returns NOP until loaded.
// Revision : 1.0
// ============================================================================
module instr_mem #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        res,
    input  logic [7:0]  i_addr,
    output logic [31:0] instruction,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        loaded,
    output logic [8:0]  ld_words,
    output logic        ld_ovf
);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_waddr;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_lanes;
    logic [8:0]  r_words;
    logic        r_ovf;
    logic [31:0] r_mem [0:255];

    logic        w_accept;
    logic        w_wr;
    logic [31:0] w_word;

    assign ld_ready    = (r_state == S_LOAD) && !ld_start;
    assign loaded      = (r_state == S_RUN);
    assign ld_words    = r_words;
    assign ld_ovf      = r_ovf;
    assign instruction = loaded ? r_mem[i_addr] : NOP_WORD;

    // Reset gates acceptance so an in-flight byte never lands in the array.
    assign w_accept = ld_valid && ld_ready && !res;
    assign w_wr     = w_accept && ((r_byte_cnt == 2'd3) || ld_last);

    // Unfilled upper lanes are already zero because r_lanes clears per word.
    always_comb begin
        w_word                              = {8'h00, r_lanes};
        w_word[{r_byte_cnt, 3'b000} +: 8]   = ld_byte;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ld_start) begin
            w_state_nxt = S_LOAD;
        end else if (w_accept && ld_last) begin
            w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_waddr    <= 8'd0;
            r_byte_cnt <= 2'd0;
            r_lanes    <= 24'd0;
            r_words    <= 9'd0;
            r_ovf      <= 1'b0;
        end else if (ld_start) begin
            r_waddr    <= 8'd0;
            r_byte_cnt <= 2'd0;
            r_lanes    <= 24'd0;
            r_words    <= 9'd0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            if (w_wr) begin
                r_waddr    <= r_waddr + 8'd1;
                r_byte_cnt <= 2'd0;
                r_lanes    <= 24'd0;
                if (r_words == 9'd256) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_words <= r_words + 9'd1;
                end
            end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_lanes    <= w_word[23:0];
            end
        end
    end

    // Array is deliberately not reset; contents survive a mid-load reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_waddr] <= w_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem
// Purpose  : Randomized self-checking bench for instr_mem against a byte-stream
//            reference model.
// Revision : 1.0
// ============================================================================
module tb_instr_mem;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        res;
    logic [7:0]  i_addr;
    logic [31:0] instruction;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        loaded;
    logic [8:0]  ld_words;
    logic        ld_ovf;

    instr_mem #(.NOP_WORD(c_NOP)) dut (
        .clk         (clk),
        .res         (res),
        .i_addr      (i_addr),
        .instruction (instruction),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_byte     (ld_byte),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .loaded      (loaded),
        .ld_words    (ld_words),
        .ld_ovf      (ld_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: image byte index since start, words written, memory image.
    bit          m_run;
    int          m_n;
    int          m_words;
    logic [31:0] m_cur;
    logic [31:0] m_mem  [256];
    bit          m_memv [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_run   = 1'b0;
        m_n     = 0;
        m_words = 0;
        m_cur   = 32'd0;
    endtask

    task automatic check_outputs();
        chk("loaded",   32'(loaded),   32'(m_run));
        chk("ld_ready", 32'(ld_ready), 32'(!m_run && !ld_start));
        chk("ld_words", 32'(ld_words), (m_words > 256) ? 256 : m_words);
        chk("ld_ovf",   32'(ld_ovf),   32'(m_words > 256));
        if (!m_run)
            chk("instr_nop", instruction, c_NOP);
        else if (m_memv[i_addr])
            chk("instr", instruction, m_mem[i_addr]);
    endtask

    task automatic cycle(input bit st, input bit v, input logic [7:0] b, input bit last);
        bit acc;
        int lane;
        ld_start = st;
        ld_valid = v;
        ld_byte  = b;
        ld_last  = last;
        i_addr   = 8'($urandom_range(0, 255));
        acc      = !m_run && !st && v;
        @(posedge clk);
        if (st) begin
            model_clear();
        end else if (acc) begin
            lane = m_n % 4;
            m_cur[lane*8 +: 8] = b;
            m_n++;
            if (lane == 3 || last) begin
                m_mem[m_words % 256]  = m_cur;
                m_memv[m_words % 256] = 1'b1;
                m_words++;
                m_cur = 32'd0;
                if (last) begin
                    m_run = 1'b1;
                    m_n   = 0;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic load_bytes(input logic [7:0] q[$], input int gap_pct);
        foreach (q[i]) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
                cycle(1'b0, 1'b0, 8'($urandom), 1'b0);
            cycle(1'b0, 1'b1, q[i], i == q.size() - 1);
        end
        cycle(1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic sweep();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        for (int a = 0; a < 256; a++) begin
            if (m_memv[a]) begin
                i_addr = 8'(a);
                @(negedge clk);
                chk("sweep", instruction, m_mem[a]);
            end
        end
    endtask

    task automatic peek(input string tag, input logic [7:0] a, input logic [31:0] exp);
        ld_valid = 1'b0;
        ld_start = 1'b0;
        i_addr   = a;
        @(negedge clk);
        chk(tag, instruction, exp);
    endtask

    task automatic async_reset();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        @(posedge clk);
        #3;
        res = 1'b1;
        #1;
        chk("async_loaded", 32'(loaded), 32'd0);
        chk("async_instr",  instruction, c_NOP);
        model_clear();
        @(negedge clk);
        res = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        int len;

        res      = 1'b1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_byte  = 8'd0;
        ld_last  = 1'b0;
        i_addr   = 8'd0;
        model_clear();
        foreach (m_memv[i]) m_memv[i] = 1'b0;
        #12;
        check_outputs();
        @(negedge clk);
        res = 1'b0;

        // Two-word program
        q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_bytes(q, 0);
        chk("prog_words", 32'(ld_words), 32'd2);
        peek("prog_w0", 8'd0, 32'h0000_0013);
        peek("prog_w1", 8'd1, 32'h0010_0093);

        // Valid pulses during RUN are ignored
        for (int i = 0; i < 12; i++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        sweep();

        // Partial final word is zero-padded
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load_bytes(q, 30);
        chk("part_words", 32'(ld_words), 32'd2);
        peek("part_w0", 8'd0, 32'hDDCC_BBAA);
        peek("part_w1", 8'd1, 32'h0000_00EE);

        // Start together with a valid byte mid-load
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        cycle(1'b0, 1'b1, 8'h11, 1'b0);
        cycle(1'b0, 1'b1, 8'h22, 1'b0);
        cycle(1'b0, 1'b1, 8'h33, 1'b0);
        cycle(1'b1, 1'b1, 8'h44, 1'b0);
        chk("restart_words",  32'(ld_words), 32'd0);
        chk("restart_loaded", 32'(loaded),   32'd0);
        q = '{8'h55, 8'h66, 8'h77, 8'h88};
        load_bytes(q, 0);
        peek("restart_w0", 8'd0, 32'h8877_6655);

        // Random images with random gaps
        for (int it = 0; it < 8; it++) begin
            cycle(1'b1, 1'b0, 8'd0, 1'b0);
            len = $urandom_range(1, 40);
            q.delete();
            for (int k = 0; k < len; k++) q.push_back(8'($urandom));
            load_bytes(q, 25);
        end
        sweep();

        // Reset mid-load keeps words already in the array
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        async_reset();
        check_outputs();
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        load_bytes(q, 0);
        peek("rst_w0", 8'd0, 32'h0403_0201);
        sweep();

        // Async reset while in RUN
        async_reset();

        // 257 words wraps and overflows
        cycle(1'b1, 1'b0, 8'd0, 1'b0);
        q.delete();
        for (int k = 0; k < 257 * 4; k++) q.push_back(8'($urandom));
        load_bytes(q, 0);
        chk("ovf_flag",  32'(ld_ovf),   32'd1);
        chk("ovf_words", 32'(ld_words), 32'd256);
        peek("ovf_w0", 8'd0, {q[1027], q[1026], q[1025], q[1024]});
        peek("ovf_w1", 8'd1, {q[7], q[6], q[5], q[4]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_mem.md
# instr_mem

Instruction memory that serves the fetch stage: 256 words × 32 bits, combinational read addressed by the fetch stage's 8-bit word address (`i_addr`), returning `instruction` in the same cycle. Before execution starts, a host loader streams the program in as bytes over a valid/ready handshake. The block assembles those bytes into little-endian words and writes them sequentially from address 0. It sits between the boot/debug loader and the IF stage, and it gates fetch until a program image is complete.

## Interface
Parameters:
- `NOP_WORD`, default 32'h0000_0013, the word returned to fetch while not loaded (addi x0,x0,0).

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `res`  in  1  asynchronous, active-high reset.
- `i_addr`  in  8  fetch word address from the IF stage.
- `instruction`  out  32  fetched word, combinational.
- `ld_start`  in  1  restart load: clear pointers and enter LOAD.
- `ld_valid`  in  1  `ld_byte` is valid this cycle.
- `ld_byte`  in  8  program byte, ascending address order.
- `ld_last`  in  1  qualifies `ld_byte` as the final byte of the image.
- `ld_ready`  out  1  block accepts a byte this cycle.
- `loaded`  out  1  image complete; fetch is served from the array.
- `ld_words`  out  9  words written since the last start, saturating at 256.
- `ld_ovf`  out  1  sticky flag: more than 256 words were written.

## Operation
- States:
  - LOAD: the reset state.
  - RUN.
- A byte is accepted when `ld_valid & ld_ready`. `ld_ready` = (state==LOAD) & ~`ld_start`.
- Byte assembly:
  - A 2-bit `byte_cnt` selects the lane. The first byte goes to [7:0], the fourth to [31:24].
  - On the 4th accepted byte, write {byte, lanes 2..0} to `mem[waddr]`, increment `waddr`, clear `byte_cnt`, and increment `ld_words` (saturating at 256).
- `waddr` is 8 bits and wraps 255→0. A write while `ld_words`==256 sets `ld_ovf`. The write still happens at the wrapped address.
- `ld_last` accepted:
  - Write the current word immediately, zero-padding the unfilled upper lanes. A word completed by its 4th byte is written exactly once.
  - Clear `byte_cnt` and go to RUN.
- RUN: `ld_ready`=0 and `ld_valid` is ignored. `ld_start` returns the block to LOAD.
- `ld_start` in either state, next edge:
  - state=LOAD.
  - `waddr`=0, `byte_cnt`=0, `ld_words`=0, `ld_ovf`=0.
  - Any byte presented in the same cycle is discarded; start wins.
- `instruction` = `loaded` ? `mem[i_addr]` : `NOP_WORD`.
- Reset clears all control state. Array contents are not reset and are unknown after power-up.

## Timing
- Reset values:
  - state=LOAD, `loaded`=0, `ld_ready`=1 (when `ld_start`=0).
  - `ld_words`=0, `ld_ovf`=0.
  - `instruction`=`NOP_WORD`.
  - Internal `waddr`=0, `byte_cnt`=0.
- Reset asserted mid-load: the partially assembled word is dropped, and words already written remain in the array.
- Read latency is 0 cycles: `instruction` follows `i_addr` combinationally, so the IF stage can register it on the same edge.
- Write latency: the word is in the array after the edge that accepts its final byte.
  - `loaded` rises on the same edge that accepts the `ld_last` byte.
  - The first valid fetch of the image is therefore in the next cycle.
- Throughput is one byte per cycle, with no bubbles while `ld_valid` stays high.
- `ld_words` and `ld_ovf` update on the accepting edge.

## Test plan
- Reset, then load bytes 13,00,00,00, 93,00,10,00 (last on the final byte):
  - `loaded`=1 in the following cycle and `ld_words`=2.
  - `i_addr`=0 → 32'h0000_0013; `i_addr`=1 → 32'h0010_0093.
- Partial word: load 5 bytes AA,BB,CC,DD,EE with last on EE → `mem[1]`=32'h0000_00EE, `ld_words`=2.
- Before load completes, any `i_addr` → 32'h0000_0013. During RUN, `ld_valid` pulses leave the array and `ld_words` unchanged.
- Load 257 words → `ld_ovf`=1, `ld_words`=256, and `mem[0]` holds word 256 (the 257th word, counting from 0).
- `ld_start` asserted together with `ld_valid` mid-load → the byte is dropped, `ld_words`=0, `loaded`=0, and a new load starts at address 0.
- Assert `res` asynchronously in RUN between edges → `loaded`=0 and `instruction`=32'h0000_0013 immediately, before the next edge.
